// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and constants for the block-level clock gate sequencer.
package clock_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ON    = 2'd0,
    DRAIN = 2'd1,
    OFF   = 2'd2,
    WAKE  = 2'd3
  } cgc_state_e;

  localparam int unsigned GATED_CNT_W = 32;

  function automatic int unsigned cgc_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cgc_timer.sv
// Loadable down-counter shared by the DRAIN idle window and the WAKE settle period.
module cgc_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clock_gate_ctrl.sv
// Clock gate sequencer: ON -> DRAIN -> OFF -> WAKE -> ON, with per-requester ack.
// Optional gated-cycle statistics counter under CLOCK_GATE_CTRL_STATS_EN.
module clock_gate_ctrl
  import clock_gate_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] busy,
  input  logic             force_on,
  output logic             clk_en,
  output logic [N_REQ-1:0] ack,
  output logic [1:0]       state_o
`ifdef CLOCK_GATE_CTRL_STATS_EN
  ,
  output logic [GATED_CNT_W-1:0] gated_cycles
`endif
);

  localparam int unsigned MAX_LOAD = cgc_max(IDLE_CYCLES, WAKE_CYCLES) - 1;
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

  if ((IDLE_CYCLES < 1) || (WAKE_CYCLES < 1)) begin : g_bad_cycles
    $error("clock_gate_ctrl: IDLE_CYCLES and WAKE_CYCLES must be >= 1");
  end
  if ((MAX_LOAD >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("clock_gate_ctrl: CNT_W too narrow for IDLE_CYCLES/WAKE_CYCLES");
  end

  cgc_state_e       state_q, state_d;
  logic             clk_en_q;
  logic [N_REQ-1:0] ack_q;
  logic             activity;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  assign activity = (|req) | (|busy) | force_on;

  cgc_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = IDLE_LOAD;
    tmr_dec  = 1'b0;
    case (state_q)
      ON: begin
        if (!activity) begin
          state_d  = DRAIN;
          tmr_load = 1'b1;
          tmr_val  = IDLE_LOAD;
        end
      end
      DRAIN: begin
        if (activity)      state_d = ON;
        else if (tmr_zero) state_d = OFF;
        else               tmr_dec = 1'b1;
      end
      OFF: begin
        if (activity) begin
          state_d  = WAKE;
          tmr_load = 1'b1;
          tmr_val  = WAKE_LOAD;
        end
      end
      WAKE: begin
        if (tmr_zero) state_d = ON;
        else          tmr_dec = 1'b1;
      end
      default: state_d = ON;
    endcase
  end

  // clk_en follows the next state so it moves together with state_q;
  // ack follows the current state, giving the one-cycle req->ack latency in ON.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ON;
      clk_en_q <= 1'b1;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      clk_en_q <= (state_d != OFF);
      ack_q    <= (state_q == ON) ? req : '0;
    end
  end

  assign clk_en  = clk_en_q;
  assign ack     = ack_q;
  assign state_o = state_q;

`ifdef CLOCK_GATE_CTRL_STATS_EN
  logic [GATED_CNT_W-1:0] gated_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gated_q <= '0;
    end else if (!clk_en_q && (gated_q != '1)) begin
      gated_q <= gated_q + 1'b1;
    end
  end

  assign gated_cycles = gated_q;
`endif

endmodule
